// File: rtl/i2c_target_regfile.sv
// I2C target with a masked address match, an internal register file reached through an
// auto-incrementing pointer, and a host-side register port. SCL/SDA are oversampled.
module i2c_target_regfile #(
    parameter logic [6:0]  I2C_ADDR    = 7'h49,
    parameter logic [6:0]  ADDR_MASK   = 7'h00,
    parameter int unsigned NUM_REGS    = 16,
    parameter int unsigned SYNC_STAGES = 2,
    localparam int unsigned PW         = $clog2(NUM_REGS)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          SCL,
    input  logic          SDA_in,
    output logic          SDA_out,
    input  logic          reg_wr_en,
    input  logic [PW-1:0] reg_wr_addr,
    input  logic [7:0]    reg_wr_data,
    input  logic [PW-1:0] reg_rd_addr,
    output logic [7:0]    reg_rd_data,
    output logic          wr_down,
    output logic [PW-1:0] wr_down_addr,
    output logic [7:0]    wr_down_data,
    output logic          busy
);

    typedef enum logic [3:0] {
        StIdle, StAddr, StAddrAck, StPtr, StPtrAck,
        StWdata, StWdataAck, StRdata, StRdataAck, StIgnore
    } state_e;

    logic [SYNC_STAGES-1:0] scl_sync_q, sda_sync_q;
    logic                   scl_prev_q, sda_prev_q;
    logic                   scl_s, sda_s;
    logic                   scl_rise, scl_fall, start_evt, stop_evt;

    state_e        state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic [6:0]    tx_q, tx_d;
    logic          rw_q, rw_d;
    logic [PW-1:0] ptr_q, ptr_d;
    logic          sda_out_q, sda_out_d;
    logic          busy_q, busy_d;
    logic          commit;
    logic [7:0]    byte_in;
    logic          addr_match;

    logic [7:0]    regs_q [NUM_REGS];
    logic          wr_down_q;
    logic [PW-1:0] wr_down_addr_q;
    logic [7:0]    wr_down_data_q;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_prev_q <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], SCL};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], SDA_in};
            scl_prev_q <= scl_s;
            sda_prev_q <= sda_s;
        end
    end

    assign scl_s     = scl_sync_q[SYNC_STAGES-1];
    assign sda_s     = sda_sync_q[SYNC_STAGES-1];
    assign scl_rise  = scl_s & ~scl_prev_q;
    assign scl_fall  = ~scl_s & scl_prev_q;
    assign start_evt = scl_s & scl_prev_q & sda_prev_q & ~sda_s;
    assign stop_evt  = scl_s & scl_prev_q & ~sda_prev_q & sda_s;

    assign byte_in    = {shift_q[6:0], sda_s};
    assign addr_match = ((shift_q[7:1] ^ I2C_ADDR) & ~ADDR_MASK) == 7'd0;

    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        tx_d      = tx_q;
        rw_d      = rw_q;
        ptr_d     = ptr_q;
        sda_out_d = sda_out_q;
        busy_d    = busy_q;
        commit    = 1'b0;

        if (stop_evt) begin
            state_d   = StIdle;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
            busy_d    = 1'b0;
        end else if (start_evt) begin
            state_d   = StAddr;
            bit_cnt_d = 4'd0;
            sda_out_d = 1'b1;
        end else begin
            unique case (state_q)
                StAddr, StPtr, StWdata: begin
                    if (scl_rise && bit_cnt_q != 4'd8) begin
                        shift_d   = byte_in;
                        bit_cnt_d = bit_cnt_q + 4'd1;
                        if (state_q == StWdata && bit_cnt_q == 4'd7) begin
                            commit = 1'b1;
                            ptr_d  = ptr_q + 1'b1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd8) begin
                        if (state_q == StAddr) begin
                            if (addr_match) begin
                                state_d   = StAddrAck;
                                sda_out_d = 1'b0;
                                busy_d    = 1'b1;
                                rw_d      = shift_q[0];
                            end else begin
                                state_d = StIgnore;
                            end
                        end else if (state_q == StPtr) begin
                            if (32'(shift_q) < NUM_REGS) begin
                                state_d   = StPtrAck;
                                sda_out_d = 1'b0;
                                ptr_d     = shift_q[PW-1:0];
                            end else begin
                                state_d = StIgnore;
                            end
                        end else begin
                            state_d   = StWdataAck;
                            sda_out_d = 1'b0;
                        end
                    end
                end
                StAddrAck: begin
                    if (scl_fall) begin
                        bit_cnt_d = 4'd0;
                        if (rw_q) begin
                            // Byte is captured here so later host writes cannot disturb it.
                            state_d   = StRdata;
                            sda_out_d = regs_q[ptr_q][7];
                            tx_d      = regs_q[ptr_q][6:0];
                        end else begin
                            state_d   = StPtr;
                            sda_out_d = 1'b1;
                        end
                    end
                end
                StPtrAck, StWdataAck: begin
                    if (scl_fall) begin
                        state_d   = StWdata;
                        bit_cnt_d = 4'd0;
                        sda_out_d = 1'b1;
                    end
                end
                StRdata: begin
                    if (scl_fall) begin
                        if (bit_cnt_q == 4'd7) begin
                            state_d   = StRdataAck;
                            bit_cnt_d = 4'd0;
                            sda_out_d = 1'b1;
                        end else begin
                            sda_out_d = tx_q[6];
                            tx_d      = {tx_q[5:0], 1'b0};
                            bit_cnt_d = bit_cnt_q + 4'd1;
                        end
                    end
                end
                StRdataAck: begin
                    // bit_cnt_q == 1 marks a master ACK waiting for the next SCL fall.
                    if (scl_rise) begin
                        ptr_d = ptr_q + 1'b1;
                        if (sda_s) begin
                            state_d = StIgnore;
                        end else begin
                            bit_cnt_d = 4'd1;
                        end
                    end else if (scl_fall && bit_cnt_q == 4'd1) begin
                        state_d   = StRdata;
                        bit_cnt_d = 4'd0;
                        sda_out_d = regs_q[ptr_q][7];
                        tx_d      = regs_q[ptr_q][6:0];
                    end
                end
                StIdle, StIgnore: begin
                    sda_out_d = 1'b1;
                end
                default: begin
                    state_d   = StIdle;
                    sda_out_d = 1'b1;
                end
            endcase
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q   <= StIdle;
            bit_cnt_q <= 4'd0;
            shift_q   <= 8'd0;
            tx_q      <= 7'd0;
            rw_q      <= 1'b0;
            ptr_q     <= '0;
            sda_out_q <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
            rw_q      <= rw_d;
            ptr_q     <= ptr_d;
            sda_out_q <= sda_out_d;
            busy_q    <= busy_d;
        end
    end

    // The I2C commit is applied last so it wins a same-index collision with the host.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs_q[i] <= 8'd0;
            end
        end else begin
            if (reg_wr_en) begin
                regs_q[reg_wr_addr] <= reg_wr_data;
            end
            if (commit) begin
                regs_q[ptr_q] <= byte_in;
            end
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_down_q      <= 1'b0;
            wr_down_addr_q <= '0;
            wr_down_data_q <= 8'd0;
        end else begin
            wr_down_q <= commit;
            if (commit) begin
                wr_down_addr_q <= ptr_q;
                wr_down_data_q <= byte_in;
            end
        end
    end

    assign SDA_out      = sda_out_q;
    assign busy         = busy_q;
    assign reg_rd_data  = regs_q[reg_rd_addr];
    assign wr_down      = wr_down_q;
    assign wr_down_addr = wr_down_addr_q;
    assign wr_down_data = wr_down_data_q;

endmodule

// File: tb/tb_i2c_target_regfile.sv
// Bench for i2c_target_regfile: host-port vector table, I2C write table, and hand-written
// sequences for read wrap, bad pointer, host collision, address mask and reset mid-read.
module tb_i2c_target_regfile;

    localparam int Q  = 8;
    localparam int PW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    logic          m_scl = 1'b1, m_sda = 1'b1, sel_mask = 1'b0;
    logic          sda_out_a, sda_out_b, bus_sda, scl_a, scl_b, sda_a, sda_b;
    logic          reg_wr_en = 1'b0;
    logic [PW-1:0] reg_wr_addr = '0, reg_rd_addr = '0, mask_rd_addr = '0;
    logic [7:0]    reg_wr_data = '0;
    logic [7:0]    reg_rd_data, mask_rd_data;
    logic          wr_down, busy, wr_down_m, busy_m;
    logic [PW-1:0] wr_down_addr, wr_down_addr_m;
    logic [7:0]    wr_down_data, wr_down_data_m;

    // Two targets on separate buses; sel_mask routes the master to one of them.
    assign bus_sda = sel_mask ? (m_sda & sda_out_b) : (m_sda & sda_out_a);
    assign scl_a   = sel_mask ? 1'b1 : m_scl;
    assign sda_a   = sel_mask ? 1'b1 : bus_sda;
    assign scl_b   = sel_mask ? m_scl : 1'b1;
    assign sda_b   = sel_mask ? bus_sda : 1'b1;

    i2c_target_regfile u_dut (
        .clock(clock), .reset(reset), .SCL(scl_a), .SDA_in(sda_a), .SDA_out(sda_out_a),
        .reg_wr_en(reg_wr_en), .reg_wr_addr(reg_wr_addr), .reg_wr_data(reg_wr_data),
        .reg_rd_addr(reg_rd_addr), .reg_rd_data(reg_rd_data), .wr_down(wr_down),
        .wr_down_addr(wr_down_addr), .wr_down_data(wr_down_data), .busy(busy)
    );

    i2c_target_regfile #(.ADDR_MASK(7'h03)) u_dut_mask (
        .clock(clock), .reset(reset), .SCL(scl_b), .SDA_in(sda_b), .SDA_out(sda_out_b),
        .reg_wr_en(1'b0), .reg_wr_addr(4'd0), .reg_wr_data(8'd0),
        .reg_rd_addr(mask_rd_addr), .reg_rd_data(mask_rd_data), .wr_down(wr_down_m),
        .wr_down_addr(wr_down_addr_m), .wr_down_data(wr_down_data_m), .busy(busy_m)
    );

    logic [11:0] wd_log [0:63];
    int          wd_n = 0, wdm_n = 0, mask_low_n = 0;

    always @(negedge clock) begin
        if (wr_down) begin
            wd_log[wd_n[5:0]] <= {wr_down_addr, wr_down_data};
            wd_n <= wd_n + 1;
        end
        if (wr_down_m) wdm_n <= wdm_n + 1;
        if (!sda_out_b) mask_low_n <= mask_low_n + 1;
    end

    int total = 0, bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic bus_bit(input logic b, input logic collide, output logic seen);
        m_sda = b;
        tick(Q);
        m_scl = 1'b1;
        if (collide) begin
            // Host write lands on the same edge as the I2C commit of this last data bit.
            tick(2);
            reg_wr_en = 1'b1; reg_wr_addr = 4'd5; reg_wr_data = 8'h11;
            tick(1);
            reg_wr_en = 1'b0;
            tick(Q - 3);
        end else begin
            tick(Q);
        end
        seen = bus_sda;
        tick(Q);
        m_scl = 1'b0;
        tick(Q);
    endtask

    task automatic send_start();
        m_sda = 1'b1; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b0; tick(Q);
    endtask

    task automatic send_stop();
        m_sda = 1'b0; tick(Q);
        m_scl = 1'b1; tick(Q);
        m_sda = 1'b1; tick(Q);
    endtask

    task automatic write_byte(input logic [7:0] b, input logic collide, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) bus_bit(b[i], collide && (i == 0), s);
        bus_bit(1'b1, 1'b0, s);
        ack = ~s;
    endtask

    task automatic read_byte(input logic m_ack, output logic [7:0] d);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            bus_bit(1'b1, 1'b0, s);
            d[i] = s;
        end
        bus_bit(~m_ack, 1'b0, s);
    endtask

    task automatic host_write(input logic [3:0] a, input logic [7:0] d);
        reg_wr_en = 1'b1; reg_wr_addr = a; reg_wr_data = d;
        tick(1);
        reg_wr_en = 1'b0;
    endtask

    task automatic peek(input logic [3:0] a, output logic [7:0] d);
        reg_rd_addr = a;
        #1 d = reg_rd_data;
    endtask

    typedef struct {
        logic       we;
        logic [3:0] wa;
        logic [7:0] wd;
        logic [3:0] ra;
        logic [7:0] exp;
    } host_vec_t;

    typedef struct {
        logic [7:0] ab, pb, db;
        logic       exp_aack, exp_pack, exp_dack;
        int         exp_n;
        logic [3:0] idx;
        logic [7:0] exp_val;
    } i2c_vec_t;

    host_vec_t hv [6];
    i2c_vec_t  iv [4];

    initial begin
        logic       ack;
        logic [7:0] d;
        int         n0, m0;

        hv[0] = '{1'b1, 4'd2,  8'h3C, 4'd2,  8'h3C};
        hv[1] = '{1'b1, 4'd7,  8'hE1, 4'd7,  8'hE1};
        hv[2] = '{1'b0, 4'd2,  8'hFF, 4'd2,  8'h3C};
        hv[3] = '{1'b1, 4'd15, 8'h80, 4'd15, 8'h80};
        hv[4] = '{1'b0, 4'd0,  8'h00, 4'd7,  8'hE1};
        hv[5] = '{1'b1, 4'd2,  8'h00, 4'd2,  8'h00};

        iv[0] = '{8'h92, 8'h0A, 8'h11, 1'b1, 1'b1, 1'b1, 1, 4'hA, 8'h11};
        iv[1] = '{8'h92, 8'h20, 8'h22, 1'b1, 1'b0, 1'b0, 0, 4'hB, 8'h00};
        iv[2] = '{8'hA0, 8'h0B, 8'h33, 1'b0, 1'b0, 1'b0, 0, 4'hB, 8'h00};
        iv[3] = '{8'h92, 8'h0F, 8'h44, 1'b1, 1'b1, 1'b1, 1, 4'hF, 8'h44};

        tick(3);
        check("reset SDA_out", sda_out_a, 1);
        check("reset busy", busy, 0);
        check("reset wr_down", wr_down, 0);
        check("reset wr_down_addr", wr_down_addr, 0);
        check("reset wr_down_data", wr_down_data, 0);
        peek(4'd9, d); check("reset reg9", d, 8'h00);
        tick(1);
        reset = 1'b1;
        tick(5);

        for (int i = 0; i < 6; i++) begin
            reg_wr_en = hv[i].we; reg_wr_addr = hv[i].wa; reg_wr_data = hv[i].wd;
            reg_rd_addr = hv[i].ra;
            tick(1);
            reg_wr_en = 1'b0;
            check($sformatf("host vec %0d", i), reg_rd_data, hv[i].exp);
        end

        // Basic two-byte write.
        n0 = wd_n;
        send_start();
        write_byte(8'h92, 1'b0, ack); check("wr addr ack", ack, 1);
        check("busy after addr", busy, 1);
        write_byte(8'h03, 1'b0, ack); check("wr ptr ack", ack, 1);
        write_byte(8'hA5, 1'b0, ack); check("wr data0 ack", ack, 1);
        write_byte(8'h5A, 1'b0, ack); check("wr data1 ack", ack, 1);
        check("busy before stop", busy, 1);
        send_stop();
        tick(4);
        check("busy after stop", busy, 0);
        check("wr_down count", wd_n - n0, 2);
        check("wr_down ev0", wd_log[n0[5:0]], {4'd3, 8'hA5});
        check("wr_down ev1", wd_log[6'(n0 + 1)], {4'd4, 8'h5A});
        peek(4'd3, d); check("reg3", d, 8'hA5);
        peek(4'd4, d); check("reg4", d, 8'h5A);

        for (int i = 0; i < 4; i++) begin
            n0 = wd_n;
            send_start();
            write_byte(iv[i].ab, 1'b0, ack); check($sformatf("tbl %0d addr ack", i), ack, iv[i].exp_aack);
            write_byte(iv[i].pb, 1'b0, ack); check($sformatf("tbl %0d ptr ack", i), ack, iv[i].exp_pack);
            write_byte(iv[i].db, 1'b0, ack); check($sformatf("tbl %0d data ack", i), ack, iv[i].exp_dack);
            send_stop();
            tick(4);
            check($sformatf("tbl %0d wr_down count", i), wd_n - n0, iv[i].exp_n);
            if (iv[i].exp_n == 1)
                check($sformatf("tbl %0d wr_down ev", i), wd_log[n0[5:0]], {iv[i].idx, iv[i].db});
            peek(iv[i].idx, d); check($sformatf("tbl %0d reg", i), d, iv[i].exp_val);
        end

        // Pointer write, repeated START, two-byte read wrapping 15 -> 0.
        host_write(4'd0, 8'hC3);
        send_start();
        write_byte(8'h92, 1'b0, ack); check("rd ptr addr ack", ack, 1);
        write_byte(8'h0F, 1'b0, ack); check("rd ptr ack", ack, 1);
        send_start();
        write_byte(8'h93, 1'b0, ack); check("rd addr ack", ack, 1);
        read_byte(1'b1, d); check("rd byte reg15", d, 8'h44);
        read_byte(1'b0, d); check("rd byte reg0 wrap", d, 8'hC3);
        tick(2);
        check("SDA released after NAK", sda_out_a, 1);
        send_stop();
        host_write(4'd1, 8'h6B);
        send_start();
        write_byte(8'h93, 1'b0, ack); check("rd2 addr ack", ack, 1);
        read_byte(1'b0, d); check("pointer at 1", d, 8'h6B);
        send_stop();

        // Out-of-range pointer: NAK, data ignored, pointer stays at 2.
        n0 = wd_n;
        send_start();
        write_byte(8'h92, 1'b0, ack); check("badptr addr ack", ack, 1);
        write_byte(8'h20, 1'b0, ack); check("badptr ptr nak", ack, 0);
        write_byte(8'h99, 1'b0, ack); check("badptr data nak", ack, 0);
        send_stop();
        tick(4);
        check("badptr no wr_down", wd_n - n0, 0);
        host_write(4'd2, 8'h5E);
        send_start();
        write_byte(8'h93, 1'b0, ack);
        read_byte(1'b0, d); check("badptr pointer unchanged", d, 8'h5E);
        send_stop();

        // Host write to reg 5 collides with the I2C commit to reg 5.
        n0 = wd_n;
        send_start();
        write_byte(8'h92, 1'b0, ack);
        write_byte(8'h05, 1'b0, ack);
        write_byte(8'h77, 1'b1, ack); check("collide data ack", ack, 1);
        send_stop();
        tick(4);
        check("collide wr_down once", wd_n - n0, 1);
        check("collide wr_down ev", wd_log[n0[5:0]], {4'd5, 8'h77});
        peek(4'd5, d); check("collide reg5", d, 8'h77);

        // Masked address target.
        tick(2);
        sel_mask = 1'b1;
        tick(2);
        m0 = wdm_n;
        send_start();
        write_byte(8'h94, 1'b0, ack); check("mask 0x4A ack", ack, 1);
        write_byte(8'h02, 1'b0, ack); check("mask ptr ack", ack, 1);
        write_byte(8'h3C, 1'b0, ack); check("mask data ack", ack, 1);
        send_stop();
        tick(4);
        check("mask wr_down", wdm_n - m0, 1);
        mask_rd_addr = 4'd2;
        #1 check("mask reg2", mask_rd_data, 8'h3C);
        m0 = wdm_n;
        n0 = mask_low_n;
        send_start();
        write_byte(8'hB2, 1'b0, ack); check("mask 0x59 nak", ack, 0);
        write_byte(8'h02, 1'b0, ack);
        write_byte(8'h99, 1'b0, ack);
        send_stop();
        tick(4);
        check("mask 0x59 SDA never low", mask_low_n - n0, 0);
        check("mask 0x59 no wr_down", wdm_n - m0, 0);
        sel_mask = 1'b0;
        tick(2);

        // Reset while the target is driving a 0 data bit.
        send_start();
        write_byte(8'h92, 1'b0, ack);
        write_byte(8'h04, 1'b0, ack);
        send_start();
        write_byte(8'h93, 1'b0, ack);
        check("mid-read SDA driven low", sda_out_a, 0);
        check("mid-read busy", busy, 1);
        m_sda = 1'b1;
        tick(Q);
        m_scl = 1'b1;
        tick(2);
        reset = 1'b0;
        #1 check("reset async SDA_out", sda_out_a, 1);
        tick(3);
        reset = 1'b1;
        tick(3);
        check("post-reset busy", busy, 0);
        peek(4'd4, d); check("post-reset reg4", d, 8'h00);
        peek(4'd3, d); check("post-reset reg3", d, 8'h00);
        tick(2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
